pipe_hazard_ctrl: RTL and testbench

Central pipeline sequencer for the 5-stage mini CPU. Generates the per-stage hold and flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers from three hazard sources: data-memory wait, load-use dependency and taken branch/jump. Tracks outstanding data-memory accesses with a small FSM and optional timeout watchdog. Sits beside the pipeline registers and drives their `flush` (and hold) inputs.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 24 ++
 rtl/pipe_hazard_ctrl_load_use_detect.sv | 23 ++
 rtl/pipe_hazard_ctrl.sv | 154 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ABORT    = 2'd2
  } state_e;

  localparam int REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] REG_X0 = '0;

  typedef struct packed {
    logic pc_hold;
    logic if_id_hold;
    logic id_ex_hold;
    logic ex_mem_hold;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
    logic mem_wb_flush;
  } ctrl_t;

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Compares the ID-stage source registers against the destination of a load in EX.
module load_use_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [REG_IDX_W-1:0] id_rs1_i,
  input  logic [REG_IDX_W-1:0] id_rs2_i,
  input  logic                 id_use_rs1_i,
  input  logic                 id_use_rs2_i,
  input  logic                 ex_memRead_i,
  input  logic [REG_IDX_W-1:0] ex_rd_i,
  output logic                 load_use_o
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_use_rs1_i & (id_rs1_i == ex_rd_i);
  assign rs2_hit = id_use_rs2_i & (id_rs2_i == ex_rd_i);

  // x0 is hardwired zero, so a load targeting it never produces a dependency
  assign load_use_o = ex_memRead_i & (ex_rd_i != REG_X0) & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hold/flush sequencer for the 5-stage CPU; MEM_TIMEOUT_EN adds the
// data-memory timeout watchdog (counter, ABORT state, sticky mem_err).
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic                 ex_memRead,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_branch_taken,
  input  logic                 mem_memRead,
  input  logic                 mem_memWrite,
  input  logic                 dmem_ready,
  output logic                 dmem_req,
  output logic                 pc_hold,
  output logic                 if_id_hold,
  output logic                 id_ex_hold,
  output logic                 ex_mem_hold,
  output logic                 if_id_flush,
  output logic                 id_ex_flush,
  output logic                 ex_mem_flush,
  output logic                 mem_wb_flush,
  output logic                 mem_err
);

  state_e state_q, state_d;
  logic   mem_req;
  logic   in_abort;
  logic   mem_stall;
  logic   load_use;
  ctrl_t  ctrl;

  load_use_detect u_load_use (
    .id_rs1_i     (id_rs1),
    .id_rs2_i     (id_rs2),
    .id_use_rs1_i (id_use_rs1),
    .id_use_rs2_i (id_use_rs2),
    .ex_memRead_i (ex_memRead),
    .ex_rd_i      (ex_rd),
    .load_use_o   (load_use)
  );

  assign mem_req = mem_memRead | mem_memWrite;

`ifdef MEM_TIMEOUT_EN
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  assign in_abort = (state_q == ST_ABORT);
  assign mem_err  = err_q;
`else
  logic unused_params;

  assign unused_params = (TIMEOUT_CYCLES > 0) ^ (CNT_W > 0);
  assign in_abort      = 1'b0;
  assign mem_err       = 1'b0;
`endif

  assign mem_stall = mem_req & ~dmem_ready & ~in_abort;

  // Hazard priority: memory stall freezes EX, so branch and load-use wait behind it
  always_comb begin
    ctrl = '0;
    if (mem_stall) begin
      ctrl.pc_hold      = 1'b1;
      ctrl.if_id_hold   = 1'b1;
      ctrl.id_ex_hold   = 1'b1;
      ctrl.ex_mem_hold  = 1'b1;
      ctrl.mem_wb_flush = 1'b1;
    end else if (in_abort) begin
      ctrl.ex_mem_flush = 1'b1;
      ctrl.mem_wb_flush = 1'b1;
    end else if (ex_branch_taken) begin
      ctrl.if_id_flush  = 1'b1;
      ctrl.id_ex_flush  = 1'b1;
    end else if (load_use) begin
      ctrl.pc_hold      = 1'b1;
      ctrl.if_id_hold   = 1'b1;
      ctrl.id_ex_flush  = 1'b1;
    end
  end

  assign dmem_req     = mem_req & ~in_abort & reset_n;
  assign pc_hold      = ctrl.pc_hold      & reset_n;
  assign if_id_hold   = ctrl.if_id_hold   & reset_n;
  assign id_ex_hold   = ctrl.id_ex_hold   & reset_n;
  assign ex_mem_hold  = ctrl.ex_mem_hold  & reset_n;
  assign if_id_flush  = ctrl.if_id_flush  & reset_n;
  assign id_ex_flush  = ctrl.id_ex_flush  & reset_n;
  assign ex_mem_flush = ctrl.ex_mem_flush & reset_n;
  assign mem_wb_flush = ctrl.mem_wb_flush & reset_n;

  always_comb begin
    state_d = state_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      ST_RUN: begin
        if (mem_req & ~dmem_ready) begin
          state_d = ST_MEM_WAIT;
`ifdef MEM_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_MEM_WAIT: begin
        if (dmem_ready) begin
          state_d = ST_RUN;
`ifdef MEM_TIMEOUT_EN
        end else if (cnt_q == CNT_LIMIT) begin
          state_d = ST_ABORT;
        end else begin
          cnt_d   = cnt_q + 1'b1;
`endif
        end
      end
`ifdef MEM_TIMEOUT_EN
      ST_ABORT: begin
        state_d = ST_RUN;
        err_d   = 1'b1;
      end
`endif
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl; define MEM_TIMEOUT_EN to exercise the watchdog.
module tb_pipe_hazard_ctrl;

  localparam int TB_TO = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_memRead, ex_branch_taken;
  logic       mem_memRead, mem_memWrite, dmem_ready;
  logic       dmem_req, pc_hold, if_id_hold, id_ex_hold, ex_mem_hold;
  logic       if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, mem_err;

  int tests = 0;
  int fails = 0;

  // reference model state: consecutive stalled cycles of the pending access, sticky error
  int pend  = 0;
  bit err_m = 1'b0;

  pipe_hazard_ctrl #(.TIMEOUT_CYCLES(TB_TO), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_memRead(ex_memRead), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .mem_memRead(mem_memRead), .mem_memWrite(mem_memWrite), .dmem_ready(dmem_ready),
    .dmem_req(dmem_req), .pc_hold(pc_hold), .if_id_hold(if_id_hold),
    .id_ex_hold(id_ex_hold), .ex_mem_hold(ex_mem_hold),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // bit order: dmem_req, pc/ifid/idex/exmem hold, ifid/idex/exmem/memwb flush, mem_err
  function automatic logic [9:0] outs();
    return {dmem_req, pc_hold, if_id_hold, id_ex_hold, ex_mem_hold,
            if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, mem_err};
  endfunction

  task automatic clear_inputs();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
    id_use_rs1 = 0; id_use_rs2 = 0; ex_memRead = 0; ex_branch_taken = 0;
    mem_memRead = 0; mem_memWrite = 0; dmem_ready = 0;
  endtask

  task automatic rand_id_ex();
    id_rs1 = 5'($urandom_range(0, 3));
    id_rs2 = 5'($urandom_range(0, 3));
    ex_rd  = 5'($urandom_range(0, 3));
    id_use_rs1 = 1'($urandom); id_use_rs2 = 1'($urandom);
    ex_memRead = 1'($urandom);
    ex_branch_taken = ($urandom_range(0, 3) == 0);
  endtask

  // Evaluates the model for the current inputs, samples the DUT mid-cycle, then advances one clock.
  task automatic run_cycle(output logic [9:0] act, output logic [9:0] exp);
    bit req, abort, stall, lu;
    req = mem_memRead || mem_memWrite;
`ifdef MEM_TIMEOUT_EN
    abort = (pend == TB_TO + 1);
`else
    abort = 1'b0;
`endif
    stall = req && !dmem_ready && !abort;
    lu = ex_memRead && (ex_rd != 0) &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    exp = '0;
    exp[9] = req && !abort;
    exp[0] = err_m;
    if (stall) begin
      exp[8:5] = 4'hF; exp[1] = 1'b1;
    end else if (abort) begin
      exp[2] = 1'b1; exp[1] = 1'b1;
    end else if (ex_branch_taken) begin
      exp[4] = 1'b1; exp[3] = 1'b1;
    end else if (lu) begin
      exp[8] = 1'b1; exp[7] = 1'b1; exp[3] = 1'b1;
    end
    @(negedge clk);
    act = outs();
    if (abort) begin
      err_m = 1'b1; pend = 0;
    end else if (stall) begin
      pend++;
    end else begin
      pend = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [9:0] act, exp;
    reset_n = 1'b0;
    clear_inputs();
    mem_memRead = 1; ex_branch_taken = 1; ex_memRead = 1; ex_rd = 3; id_rs1 = 3; id_use_rs1 = 1;
    #2;
    tests++;
    if (outs() !== 10'b0) begin
      fails++; $display("FAIL reset_async: got %b want %b", outs(), 10'b0);
    end
    @(posedge clk); #3;
    tests++;
    if (outs() !== 10'b0) begin
      fails++; $display("FAIL reset_held: got %b want %b", outs(), 10'b0);
    end
    clear_inputs();
    reset_n = 1'b1;
    pend = 0; err_m = 1'b0;
    @(posedge clk); #1;
    run_cycle(act, exp);
    tests++;
    if (act !== 10'b0) begin
      fails++; $display("FAIL reset_idle: got %b want %b", act, 10'b0);
    end
  endtask

  task automatic test_load_use();
    logic [9:0] act, exp;
    clear_inputs();
    ex_memRead = 1; ex_rd = 5; id_rs1 = 3; id_rs2 = 5; id_use_rs1 = 1; id_use_rs2 = 1;
    run_cycle(act, exp);
    tests++;
    if (act !== 10'b0110001000) begin
      fails++; $display("FAIL lu_x5: got %b want %b", act, 10'b0110001000);
    end
    ex_memRead = 0;
    run_cycle(act, exp);
    tests++;
    if (act !== 10'b0) begin
      fails++; $display("FAIL lu_after_bubble: got %b want %b", act, 10'b0);
    end
    ex_memRead = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1; id_rs2 = 0; id_use_rs2 = 1;
    run_cycle(act, exp);
    tests++;
    if (act !== 10'b0) begin
      fails++; $display("FAIL lu_x0: got %b want %b", act, 10'b0);
    end
    ex_rd = 7; id_rs1 = 7; id_use_rs1 = 0; id_rs2 = 2; id_use_rs2 = 1;
    run_cycle(act, exp);
    tests++;
    if (act !== 10'b0) begin
      fails++; $display("FAIL lu_unused_src: got %b want %b", act, 10'b0);
    end
    ex_rd = 7; id_rs1 = 7; id_use_rs1 = 1;
    run_cycle(act, exp);
    tests++;
    if (act !== 10'b0110001000) begin
      fails++; $display("FAIL lu_rs1: got %b want %b", act, 10'b0110001000);
    end
    for (int i = 0; i < 60; i++) begin
      clear_inputs();
      rand_id_ex();
      run_cycle(act, exp);
      tests++;
      if (act !== exp) begin
        fails++; $display("FAIL lu_rand[%0d]: got %b want %b", i, act, exp);
      end
    end
  endtask

  task automatic test_branch_priority();
    logic [9:0] act, exp;
    clear_inputs();
    ex_memRead = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1; ex_branch_taken = 1;
    run_cycle(act, exp);
    tests++;
    if (act !== 10'b0000011000) begin
      fails++; $display("FAIL branch_over_lu: got %b want %b", act, 10'b0000011000);
    end
  endtask

  task automatic test_mem_wait();
    logic [9:0] act, exp;
    clear_inputs();
    mem_memRead = 1;
    run_cycle(act, exp);
    tests++;
    if (act !== 10'b1111100010) begin
      fails++; $display("FAIL memwait_c1: got %b want %b", act, 10'b1111100010);
    end
    ex_branch_taken = 1; ex_memRead = 1; ex_rd = 4; id_rs1 = 4; id_use_rs1 = 1;
    run_cycle(act, exp);
    tests++;
    if (act !== 10'b1111100010) begin
      fails++; $display("FAIL memwait_c2_ignores_branch: got %b want %b", act, 10'b1111100010);
    end
    clear_inputs();
    mem_memRead = 1; dmem_ready = 1;
    run_cycle(act, exp);
    tests++;
    if (act !== 10'b1000000000) begin
      fails++; $display("FAIL memwait_ready: got %b want %b", act, 10'b1000000000);
    end
    clear_inputs();
    mem_memWrite = 1; dmem_ready = 1;
    run_cycle(act, exp);
    tests++;
    if (act !== 10'b1000000000) begin
      fails++; $display("FAIL mem_zero_wait: got %b want %b", act, 10'b1000000000);
    end
    clear_inputs();
    run_cycle(act, exp);
    tests++;
    if (act !== 10'b0) begin
      fails++; $display("FAIL mem_idle: got %b want %b", act, 10'b0);
    end
  endtask

  task automatic test_timeout();
    logic [9:0] act, exp;
    clear_inputs();
`ifdef MEM_TIMEOUT_EN
    // ready arrives on the last MEM_WAIT cycle before the limit: no abort
    mem_memWrite = 1;
    for (int i = 0; i < TB_TO; i++) begin
      run_cycle(act, exp);
      tests++;
      if (act !== 10'b1111100010) begin
        fails++; $display("FAIL to_edge_stall[%0d]: got %b want %b", i, act, 10'b1111100010);
      end
    end
    dmem_ready = 1;
    run_cycle(act, exp);
    tests++;
    if (act !== 10'b1000000000) begin
      fails++; $display("FAIL to_edge_ready: got %b want %b", act, 10'b1000000000);
    end
    clear_inputs();
    run_cycle(act, exp);
    tests++;
    if (act !== 10'b0) begin
      fails++; $display("FAIL to_edge_no_err: got %b want %b", act, 10'b0);
    end
    mem_memRead = 1;
    for (int i = 0; i < TB_TO + 1; i++) begin
      run_cycle(act, exp);
      tests++;
      if (act !== 10'b1111100010) begin
        fails++; $display("FAIL to_stall[%0d]: got %b want %b", i, act, 10'b1111100010);
      end
    end
    run_cycle(act, exp);
    tests++;
    if (act !== 10'b0000000110) begin
      fails++; $display("FAIL to_abort: got %b want %b", act, 10'b0000000110);
    end
    clear_inputs();
    for (int i = 0; i < 2; i++) begin
      run_cycle(act, exp);
      tests++;
      if (act !== 10'b0000000001) begin
        fails++; $display("FAIL to_err_sticky[%0d]: got %b want %b", i, act, 10'b0000000001);
      end
    end
`else
    mem_memRead = 1;
    for (int i = 0; i < 12; i++) begin
      run_cycle(act, exp);
      tests++;
      if (act !== 10'b1111100010) begin
        fails++; $display("FAIL wait_forever[%0d]: got %b want %b", i, act, 10'b1111100010);
      end
    end
    dmem_ready = 1;
    run_cycle(act, exp);
    tests++;
    if (act !== 10'b1000000000) begin
      fails++; $display("FAIL wait_forever_ready: got %b want %b", act, 10'b1000000000);
    end
    clear_inputs();
`endif
  endtask

  task automatic test_back_to_back();
    logic [9:0] act, exp;
    int lat;
    for (int t = 0; t < 30; t++) begin
      lat = $urandom_range(1, 6);
      for (int c = 1; c <= lat; c++) begin
        clear_inputs();
        rand_id_ex();
        if ($urandom_range(0, 1) == 0) mem_memRead = 1; else mem_memWrite = 1;
        dmem_ready = (c == lat);
        run_cycle(act, exp);
        tests++;
        if (act !== exp) begin
          fails++; $display("FAIL b2b[%0d.%0d]: got %b want %b", t, c, act, exp);
        end
      end
      if ($urandom_range(0, 1) == 0) begin
        clear_inputs();
        rand_id_ex();
        run_cycle(act, exp);
        tests++;
        if (act !== exp) begin
          fails++; $display("FAIL b2b_idle[%0d]: got %b want %b", t, act, exp);
        end
      end
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_wait();
    logic [9:0] act, exp;
    clear_inputs();
    mem_memRead = 1;
    run_cycle(act, exp);
    run_cycle(act, exp);
    tests++;
    if (act !== 10'b1111100010) begin
      fails++; $display("FAIL rmw_pre: got %b want %b", act, 10'b1111100010);
    end
    ex_branch_taken = 1;
    #2;
    reset_n = 1'b0;
    #1;
    tests++;
    if (outs() !== 10'b0) begin
      fails++; $display("FAIL rmw_async_zero: got %b want %b", outs(), 10'b0);
    end
    @(posedge clk); #2;
    clear_inputs();
    reset_n = 1'b1;
    pend = 0; err_m = 1'b0;
    @(posedge clk); #1;
    run_cycle(act, exp);
    tests++;
    if (act !== 10'b0) begin
      fails++; $display("FAIL rmw_post_idle: got %b want %b", act, 10'b0);
    end
    mem_memWrite = 1;
    for (int i = 0; i < TB_TO + 3; i++) begin
      run_cycle(act, exp);
      tests++;
      if (act !== exp) begin
        fails++; $display("FAIL rmw_fresh[%0d]: got %b want %b", i, act, exp);
      end
    end
    clear_inputs();
    run_cycle(act, exp);
    tests++;
    if (act !== exp) begin
      fails++; $display("FAIL rmw_tail: got %b want %b", act, exp);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_priority();
    test_mem_wait();
    test_timeout();
    test_back_to_back();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
